arm_alu_seq: RTL and testbench
==============================

// Module: arm_alu_seq
// PURPOSE
//  Parametrised, sequential successor to the single-cycle datapath ALU. Executes
//  single-cycle ops (add/sub/mov/lsr1/dec/pass) and multi-cycle ops (LSR by N,
//  iterative multiply) under a start/ready/done handshake.
//  Result and NZCV flags are registered. Sits between register-file read ports
//  and the writeback mux, under control of the instruction-sequencing FSM.
// PARAMETERS
//  DATA_W   16  operand/result width in bits (>=4)
//  SHAMT_W  4   shift-amount width; must satisfy 2**SHAMT_W >= DATA_W
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        synchronous, active-high reset
//  start    in   1        launch op; sampled only when ready=1
//  op       in   3        opcode (see BEHAVIOUR)
//  cin      in   1        carry-in for MOV
//  rd_data  in   DATA_W   operand A (destination register value)
//  rs_data  in   DATA_W   operand B (source register value)
//  shamt    in   SHAMT_W  shift count for LSRN
//  ready    out  1        1 = idle, start accepted
//  done     out  1        1-cycle pulse: d_out/flags valid for the completed op
//  wen      out  1        register-file write enable; equals done
//  d_out    out  DATA_W   registered result; holds until the next done
//  flags    out  4        registered {N,Z,C,V}
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, done=0, wen=0, d_out=0, flags=4'b0100 (Z=1).
//  Opcodes: 0 ADD A+B | 1 SUB A+~B+1 | 2 MOV B+cin | 3 LSR1 {0,B[W-1:1]} |
//   4 DEC B-1 | 5 LSRN B>>shamt | 6 MUL low DATA_W of A*B | 7 PASS A.
//  Operands, op, cin and shamt are captured on the accepting edge; later input
//   changes have no effect on the op in flight.
//  FSM: IDLE -(start, single-cycle op)-> DONE
//       IDLE -(start, op 5/6)-> EXEC; EXEC -(iteration count hit)-> DONE
//       DONE -> IDLE. done=1 in the DONE state only. ready=1 in IDLE only.
//  Latency, accepting edge to done: single-cycle ops 1 cycle. LSRN: shamt+1
//   cycles (shamt=0 gives 1 cycle). MUL: DATA_W+1 cycles. Back-to-back ops:
//   next start accepted the cycle after done.
//  start while ready=0 is ignored (no queueing, no error).
//  Arithmetic: all results are modulo 2**DATA_W.
//   ADD/SUB/MOV/DEC: C = carry out of bit DATA_W-1; for SUB and DEC, C=1 means
//    no borrow.
//   ADD/SUB: V = signed overflow. MOV/DEC: V unchanged.
//   LSR1/LSRN: C = last bit shifted out; unchanged if shamt=0; V unchanged.
//   MUL/PASS: C and V unchanged.
//  N = d_out[DATA_W-1] and Z = (d_out==0) for every op.
//  Flags update only on the done edge.
//  LSRN with shamt >= DATA_W gives d_out=0 and C = B[DATA_W-1] (shift saturates
//   after DATA_W iterations).
//  rst asserted mid-EXEC aborts the op: the next cycle is IDLE with reset
//   values, and no done pulse is produced.
// CONFIGURATION
//  ARM_ALU_MUL_EN defined: op 6 is an iterative shift-add multiply as above.
//  Not defined: op 6 is treated as PASS (1 cycle, d_out=A). No multiplier
//   logic is synthesised.
// STRUCTURE
//  Package arm_alu_pkg: opcode localparams (OP_ADD..OP_PASS), FSM state
//   encoding (ST_IDLE/ST_EXEC/ST_DONE), flag bit indices (FLG_N/Z/C/V).
//  Sub-module arm_alu_iter: iterative engine for LSRN and MUL, containing the
//   shift register, accumulator and iteration counter, with load/step/last
//   signals. The top level holds the FSM, the single-cycle ops and the flag
//   logic.
// TESTING
//  All vectors use DATA_W=16.
//  ADD A=FFFF B=0001 -> 1 cycle: d_out=0000, flags N0 Z1 C1 V0, done=wen=1
//   for 1 cycle.
//  SUB A=0005 B=0007 -> d_out=FFFE, N1 Z0 C0 V0.
//  ADD A=7FFF B=0001 -> d_out=8000, N1 V1.
//  LSRN B=8000 shamt=15 -> done 16 cycles after accept: d_out=0001, C0.
//  LSRN B=8000 shamt=0 -> done after 1 cycle: d_out=8000, C unchanged.
//  MUL (MUL_EN) A=0012 B=0034 -> done 17 cycles after accept: d_out=03A8.
//   Without MUL_EN: d_out=0012 after 1 cycle.
//  Pulse start during EXEC of MUL -> ignored; exactly one done.
//   rst mid-MUL -> next cycle ready=1, d_out=0, flags=0100, no done.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Purpose : shared opcodes, FSM state encoding and flag bit positions for arm_alu_seq.
// Latency : n/a (declarations only).
// Backpres: n/a.
package arm_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_LSR1 = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_LSRN = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the {N,Z,C,V} flags vector.
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/arm_alu_iter.sv
// Purpose : iterative engine for LSRN (one bit per step) and shift-add MUL.
// Latency : one step per cycle; o_res/o_c show the result of the step in progress.
// Backpres: none; driven by load/step strobes from the sequencing FSM.
//
// Ports: clk/rst        clock, synchronous active-high reset
//        i_load         capture operands and iteration count
//        i_step         perform one iteration
//        i_mul          1 = multiply, 0 = logical shift right (captured on load)
//        i_a, i_b       multiplicand / shift-or-multiplier operand
//        i_cnt          number of iterations (>=1)
//        o_last         the current step is the final one
//        o_res, o_c     result and shifted-out bit after the current step
// Multiplier datapath exists only when ARM_ALU_MUL_EN is defined.
module arm_alu_iter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_mul,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [CNT_W-1:0]  i_cnt,
    output logic              o_last,
    output logic [DATA_W-1:0] o_res,
    output logic              o_c
);

    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_sh_nxt;

    assign w_sh_nxt = {1'b0, r_sh[DATA_W-1:1]};
    assign o_c      = r_sh[0];
    assign o_last   = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_b;
            r_cnt <= i_cnt;
        end else if (i_step) begin
            r_sh  <= w_sh_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef ARM_ALU_MUL_EN
    // Multiplier bits come off r_sh[0]; multiplicand moves left each step.
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic              r_mul;
    logic [DATA_W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_sh[0] ? (r_acc + r_mcand) : r_acc;
    assign o_res     = r_mul ? w_acc_nxt : w_sh_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mul   <= 1'b0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= i_a;
            r_mul   <= i_mul;
        end else if (i_step) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= {r_mcand[DATA_W-2:0], 1'b0};
        end
    end
`else
    logic w_unused_mul;
    assign w_unused_mul = ^{i_mul, i_a};
    assign o_res        = w_sh_nxt;
`endif

endmodule

// File: rtl/arm_alu_seq.sv
// Purpose : sequential ALU with registered result and NZCV flags, start/ready/done handshake.
// Latency : 1 cycle single-cycle ops; LSRN min(shamt,DATA_W)+1; MUL DATA_W+1.
// Backpres: start ignored while ready=0 (no queueing); next op accepted the cycle after done.
//
// Ports: clk, rst (sync, active-high), start, op[2:0], cin, rd_data (A), rs_data (B), shamt
//        ready (idle), done (1-cycle pulse), wen (= done), d_out, flags {N,Z,C,V}
// Optional feature: ARM_ALU_MUL_EN enables the iterative multiply for op 6;
// without it op 6 behaves as PASS.
module arm_alu_seq
    import arm_alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               cin,
    input  logic [DATA_W-1:0]  rd_data,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               done,
    output logic               wen,
    output logic [DATA_W-1:0]  d_out,
    output logic [3:0]         flags
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W:0] W_ONE = {{DATA_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_nxt_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_d_out;
    logic [3:0]        r_flags;

    logic              w_accept;
    logic              w_go_exec;
    logic              w_upd;
    logic [CNT_W-1:0]  w_lsr_cnt;
    logic [CNT_W-1:0]  w_it_cnt;
    logic              w_it_last;
    logic [DATA_W-1:0] w_it_res;
    logic              w_it_c;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_sc_res;
    logic              w_sc_c;
    logic              w_sc_v;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;

    assign w_accept = (r_state == ST_IDLE) && start;

    // LSRN by zero has nothing to iterate and completes like a single-cycle op.
`ifdef ARM_ALU_MUL_EN
    assign w_go_exec = (op == OP_MUL) || ((op == OP_LSRN) && (shamt != '0));
`else
    assign w_go_exec = (op == OP_LSRN) && (shamt != '0);
`endif

    // Shifting further than DATA_W is indistinguishable from DATA_W shifts.
    always_comb begin
        if (32'(shamt) >= DATA_W) w_lsr_cnt = CNT_W'(DATA_W);
        else                      w_lsr_cnt = CNT_W'(shamt);
    end

    assign w_it_cnt = (op == OP_MUL) ? CNT_W'(DATA_W) : w_lsr_cnt;

    arm_alu_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept && w_go_exec),
        .i_step (r_state == ST_EXEC),
        .i_mul  (op == OP_MUL),
        .i_a    (rd_data),
        .i_b    (rs_data),
        .i_cnt  (w_it_cnt),
        .o_last (w_it_last),
        .o_res  (w_it_res),
        .o_c    (w_it_c)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt_state;
    end

    // FSM: next state
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_nxt_state = w_go_exec ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_it_last) w_nxt_state = ST_DONE;
            ST_DONE: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = (r_state == ST_IDLE);
        done  = (r_state == ST_DONE);
        wen   = (r_state == ST_DONE);
    end

    // Single-cycle results straight from the inputs on the accepting edge.
    always_comb begin
        w_sum    = '0;
        w_sc_res = rd_data;
        w_sc_c   = r_flags[FLG_C];
        w_sc_v   = r_flags[FLG_V];
        case (op)
            OP_ADD: begin
                w_sum    = {1'b0, rd_data} + {1'b0, rs_data};
                w_sc_res = w_sum[DATA_W-1:0];
                w_sc_c   = w_sum[DATA_W];
                w_sc_v   = (rd_data[DATA_W-1] == rs_data[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != rd_data[DATA_W-1]);
            end
            OP_SUB: begin
                w_sum    = {1'b0, rd_data} + {1'b0, ~rs_data} + W_ONE;
                w_sc_res = w_sum[DATA_W-1:0];
                w_sc_c   = w_sum[DATA_W];
                w_sc_v   = (rd_data[DATA_W-1] != rs_data[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != rd_data[DATA_W-1]);
            end
            OP_MOV: begin
                w_sum    = {1'b0, rs_data} + {{DATA_W{1'b0}}, cin};
                w_sc_res = w_sum[DATA_W-1:0];
                w_sc_c   = w_sum[DATA_W];
            end
            OP_LSR1: begin
                w_sc_res = {1'b0, rs_data[DATA_W-1:1]};
                w_sc_c   = rs_data[0];
            end
            OP_DEC: begin
                // B + all-ones: carry out is 1 unless B was zero (borrow).
                w_sum    = {1'b0, rs_data} + {1'b0, {DATA_W{1'b1}}};
                w_sc_res = w_sum[DATA_W-1:0];
                w_sc_c   = w_sum[DATA_W];
            end
            OP_LSRN: w_sc_res = rs_data;   // only reached with shamt == 0
            default: w_sc_res = rd_data;   // PASS, and MUL when disabled
        endcase
    end

    // Select the completing result: single-cycle path or final iteration.
    always_comb begin
        w_res = w_sc_res;
        w_c   = w_sc_c;
        w_v   = w_sc_v;
        if (r_state == ST_EXEC) begin
            w_res = w_it_res;
            w_c   = (r_op == OP_LSRN) ? w_it_c : r_flags[FLG_C];
            w_v   = r_flags[FLG_V];
        end
    end

    assign w_upd = (w_accept && !w_go_exec) || ((r_state == ST_EXEC) && w_it_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_ADD;
            r_d_out <= '0;
            r_flags <= 4'b0100;
        end else begin
            if (w_accept) r_op <= op;
            if (w_upd) begin
                r_d_out        <= w_res;
                r_flags[FLG_N] <= w_res[DATA_W-1];
                r_flags[FLG_Z] <= (w_res == '0);
                r_flags[FLG_C] <= w_c;
                r_flags[FLG_V] <= w_v;
            end
        end
    end

    assign d_out = r_d_out;
    assign flags = r_flags;

endmodule

// File: tb/tb_arm_alu_seq.sv
// Purpose : directed self-checking bench for arm_alu_seq at DATA_W=16.
// Latency : counts cycles from the accepting edge to the done pulse.
// Backpres: exercises start while busy and reset during a multi-cycle op.
module tb_arm_alu_seq;
    import arm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        cin;
    logic [15:0] rd_data;
    logic [15:0] rs_data;
    logic [3:0]  shamt;
    logic        ready;
    logic        done;
    logic        wen;
    logic [15:0] d_out;
    logic [3:0]  flags;

    int n_chk  = 0;
    int n_fail = 0;

    arm_alu_seq #(.DATA_W(16), .SHAMT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .cin     (cin),
        .rd_data (rd_data),
        .rs_data (rs_data),
        .shamt   (shamt),
        .ready   (ready),
        .done    (done),
        .wen     (wen),
        .d_out   (d_out),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble the inputs after acceptance, and check the completion.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic c, input logic [3:0] sh,
                          input logic [15:0] exp_d, input logic [3:0] exp_f, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        op = o; rd_data = a; rs_data = b; cin = c; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; rd_data = ~a; rs_data = ~b; cin = ~c; shamt = ~sh;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check({tag, "_lat"},   32'(lat),   32'(exp_lat));
        check({tag, "_d"},     32'(d_out), 32'(exp_d));
        check({tag, "_flags"}, 32'(flags), 32'(exp_f));
        check({tag, "_wen"},   32'(wen),   32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done),  32'd0);
    endtask

    initial begin
        logic [2:0]  long_op;
        logic [15:0] long_a;
        logic [15:0] long_b;
        logic [3:0]  long_sh;
        logic [15:0] long_d;
        int          long_lat;
        int          n_done;
        int          first;

`ifdef ARM_ALU_MUL_EN
        long_op = OP_MUL;  long_a = 16'h0012; long_b = 16'h0034; long_sh = 4'd0;
        long_d  = 16'h03A8; long_lat = 17;
`else
        long_op = OP_LSRN; long_a = 16'h0000; long_b = 16'hFFFF; long_sh = 4'd15;
        long_d  = 16'h0001; long_lat = 16;
`endif

        rst = 1'b1; start = 1'b0; op = OP_ADD; cin = 1'b0;
        rd_data = '0; rs_data = '0; shamt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done),  32'd0);
        check("rst_wen",   32'(wen),   32'd0);
        check("rst_d",     32'(d_out), 32'h0);
        check("rst_flags", 32'(flags), 32'h4);

        run_op("add_wrap", OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 4'd0,  16'h0000, 4'b0110, 1);
        run_op("sub_neg",  OP_SUB,  16'h0005, 16'h0007, 1'b0, 4'd0,  16'hFFFE, 4'b1000, 1);
        run_op("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 4'd0,  16'h8000, 4'b1001, 1);
        run_op("mov_cin",  OP_MOV,  16'h0000, 16'hFFFF, 1'b1, 4'd0,  16'h0000, 4'b0111, 1);
        run_op("dec_zero", OP_DEC,  16'h0000, 16'h0000, 1'b0, 4'd0,  16'hFFFF, 4'b1001, 1);
        run_op("lsr1",     OP_LSR1, 16'h0000, 16'h0003, 1'b0, 4'd0,  16'h0001, 4'b0011, 1);
        run_op("lsrn15",   OP_LSRN, 16'h0000, 16'h8000, 1'b0, 4'd15, 16'h0001, 4'b0001, 16);
        run_op("add_c",    OP_ADD,  16'hFFFF, 16'h0002, 1'b0, 4'd0,  16'h0001, 4'b0010, 1);
        run_op("lsrn0",    OP_LSRN, 16'h0000, 16'h8000, 1'b0, 4'd0,  16'h8000, 4'b1010, 1);
        run_op("lsrn3",    OP_LSRN, 16'h0000, 16'h00B5, 1'b0, 4'd3,  16'h0016, 4'b0010, 4);
        run_op("dec_8000", OP_DEC,  16'h0000, 16'h8000, 1'b0, 4'd0,  16'h7FFF, 4'b0010, 1);
        run_op("pass",     OP_PASS, 16'h1234, 16'h5678, 1'b0, 4'd0,  16'h1234, 4'b0010, 1);
`ifdef ARM_ALU_MUL_EN
        run_op("mul",      OP_MUL,  16'h0012, 16'h0034, 1'b0, 4'd0,  16'h03A8, 4'b0010, 17);
`else
        run_op("mul",      OP_MUL,  16'h0012, 16'h0034, 1'b0, 4'd0,  16'h0012, 4'b0010, 1);
`endif

        // start pulsed while a multi-cycle op is running must be ignored.
        @(negedge clk);
        op = long_op; rd_data = long_a; rs_data = long_b; shamt = long_sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        first  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check("busy_ready", 32'(ready), 32'd0);
                start = 1'b1; op = OP_ADD; rd_data = 16'h0001; rs_data = 16'h0001;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first == 0) begin
                    first = i;
                    check("busy_d", 32'(d_out), 32'(long_d));
                end
            end
        end
        start = 1'b0;
        check("busy_ndone", 32'(n_done), 32'd1);
        check("busy_lat",   32'(first),  32'(long_lat));

        // Reset in the middle of a multi-cycle op aborts it without a done pulse.
        @(negedge clk);
        op = long_op; rd_data = long_a; rs_data = long_b; shamt = long_sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done",  32'(done),  32'd0);
        check("abort_d",     32'(d_out), 32'h0);
        check("abort_flags", 32'(flags), 32'h4);
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_ndone", 32'(n_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
